// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the Colorus fetch stage: instruction field bounds,
// opcode encodings, the NOP bubble word and default widths.
package instruction_fetch_unit_pkg;

  localparam int INSN_W_DEF = 28;
  localparam int ADDR_W_DEF = 16;

  // Instruction field bounds
  localparam int OP_MSB  = 27;
  localparam int OP_LSB  = 24;
  localparam int TGT_MSB = 23;
  localparam int TGT_LSB = 16;

  // Opcode encodings
  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_CALL = 4'hB;
  localparam logic [3:0] OP_RET  = 4'hC;

  // Word handed to execute when nothing real is issued
  localparam logic [27:0] NOP_BUBBLE = {OP_NOP, 24'd0};

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  function automatic logic [3:0] get_opcode(input logic [27:0] word);
    return word[OP_MSB:OP_LSB];
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_ras.sv
// Return-address stack for the fetch stage. LIFO of STACK_DEPTH entries;
// top is readable combinationally so RET can redirect in the fetch cycle.
// A push when full or a pop when empty is ignored; the caller flags it.
module return_address_stack #(
  parameter int STACK_DEPTH = 8,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] top,
  output logic              full,
  output logic              empty
);

  // One extra pointer bit distinguishes full from empty
  localparam int PTR_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [PTR_W-1:0] ONE_SP   = 1;
  localparam logic [PTR_W-2:0] ONE_IDX  = 1;
  localparam logic [PTR_W-1:0] DEPTH_SP = PTR_W'(STACK_DEPTH);

  logic [ADDR_W-1:0] mem [STACK_DEPTH];
  logic [PTR_W-1:0]  sp_reg;
  logic [PTR_W-2:0]  top_idx;

  assign full    = (sp_reg == DEPTH_SP);
  assign empty   = (sp_reg == '0);
  assign top_idx = sp_reg[PTR_W-2:0] - ONE_IDX;
  assign top     = mem[top_idx];

  // Stack pointer: count of live entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp_reg <= '0;
    end else if (push && !full) begin
      sp_reg <= sp_reg + ONE_SP;
    end else if (pop && !empty) begin
      sp_reg <= sp_reg - ONE_SP;
    end
  end

  // Entry storage; contents need no reset because the pointer gates them
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp_reg[PTR_W-2:0]] <= push_data;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Colorus fetch stage: PC, ROM address, issue register, and local
// resolution of JMP/CALL/RET. Stack misuse halts fetch until Reset.
// Optional macro IFU_PERF_CNT_EN adds a 32-bit issued-instruction counter
// on port oFetchCount.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int INSN_W      = INSN_W_DEF
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic [ADDR_W-1:0] oAddress,
  input  logic [INSN_W-1:0] iInstruction,
  input  logic              iStall,
  input  logic              iBranchTaken,
  input  logic [ADDR_W-1:0] iBranchTarget,
  output logic [INSN_W-1:0] oInstruction,
  output logic              oInstrValid,
`ifdef IFU_PERF_CNT_EN
  output logic [31:0]       oFetchCount,
`endif
  output logic              oStackError
);

  localparam logic [ADDR_W-1:0] ONE_PC = 1;

  fetch_state_t      state_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] pc_plus1;
  logic [ADDR_W-1:0] jump_target;
  logic [ADDR_W-1:0] stack_top;
  logic [3:0]        opcode;
  logic              stack_full;
  logic              stack_empty;
  logic              issue;
  logic              is_call;
  logic              is_ret;
  logic              stack_fault;
  logic              push;
  logic              pop;

  assign opcode      = get_opcode(iInstruction[27:0]);
  assign jump_target = ADDR_W'(iInstruction[TGT_MSB:TGT_LSB]);
  assign pc_plus1    = pc_reg + ONE_PC;
  assign oAddress    = pc_reg;

  // A word is issued only when running, not redirected and not stalled;
  // a squashed CALL/RET therefore never touches the stack.
  assign issue       = (state_reg == ST_RUN) && !iBranchTaken && !iStall;
  assign is_call     = (opcode == OP_CALL);
  assign is_ret      = (opcode == OP_RET);
  assign stack_fault = issue && ((is_call && stack_full) || (is_ret && stack_empty));
  assign push        = issue && is_call && !stack_full;
  assign pop         = issue && is_ret && !stack_empty;

  return_address_stack #(
    .STACK_DEPTH (STACK_DEPTH),
    .ADDR_W      (ADDR_W)
  ) u_ras (
    .clk       (Clock),
    .rst       (Reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_plus1),
    .top       (stack_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  // Next PC selected by the fetched opcode; a faulting CALL/RET holds PC
  always_comb begin
    pc_next = pc_plus1;
    case (opcode)
      OP_JMP:  pc_next = jump_target;
      OP_CALL: pc_next = stack_full ? pc_reg : jump_target;
      OP_RET:  pc_next = stack_empty ? pc_reg : stack_top;
      default: pc_next = pc_plus1;
    endcase
  end

  // RUN/HALT fetch FSM with registered PC, issue word, valid and error
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_reg    <= ST_RUN;
      pc_reg       <= '0;
      oInstruction <= INSN_W'(NOP_BUBBLE);
      oInstrValid  <= 1'b0;
      oStackError  <= 1'b0;
    end else begin
      case (state_reg)
        ST_RUN: begin
          if (iBranchTaken) begin
            pc_reg       <= iBranchTarget;
            oInstruction <= INSN_W'(NOP_BUBBLE);
            oInstrValid  <= 1'b0;
          end else if (!iStall) begin
            oInstruction <= iInstruction;
            pc_reg       <= pc_next;
            if (stack_fault) begin
              oInstrValid <= 1'b0;
              oStackError <= 1'b1;
              state_reg   <= ST_HALT;
            end else begin
              oInstrValid <= 1'b1;
            end
          end
        end
        ST_HALT: begin
          oInstrValid <= 1'b0;
        end
        default: begin
          state_reg <= ST_HALT;
        end
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Count every cycle that loads a valid instruction into the issue register
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      oFetchCount <= '0;
    end else if (issue && !stack_fault) begin
      oFetchCount <= oFetchCount + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios with literal
// expectations plus randomized ROM/stall/redirect traffic, all compared
// every cycle against a queue-based behavioural model of the fetch stage.
module tb_instruction_fetch_unit;
  import instruction_fetch_unit_pkg::*;

  localparam int DEPTH = 8;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] oAddress;
  logic [27:0] iInstruction;
  logic        iStall = 1'b0;
  logic        iBranchTaken = 1'b0;
  logic [15:0] iBranchTarget = '0;
  logic [27:0] oInstruction;
  logic        oInstrValid;
  logic        oStackError;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] oFetchCount;
`endif

  logic [27:0] rom [0:65535];
  assign iInstruction = rom[oAddress];

  instruction_fetch_unit #(.STACK_DEPTH(DEPTH), .ADDR_W(16), .INSN_W(28)) dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .oAddress      (oAddress),
    .iInstruction  (iInstruction),
    .iStall        (iStall),
    .iBranchTaken  (iBranchTaken),
    .iBranchTarget (iBranchTarget),
    .oInstruction  (oInstruction),
    .oInstrValid   (oInstrValid),
`ifdef IFU_PERF_CNT_EN
    .oFetchCount   (oFetchCount),
`endif
    .oStackError   (oStackError)
  );

  always #5 Clock = ~Clock;

  // Behavioural model state
  logic [15:0] m_pc;
  logic [15:0] m_stack [$];
  logic [27:0] m_instr;
  bit          m_valid;
  bit          m_err;
  logic [31:0] m_cnt;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("addr",  32'(oAddress),     32'(m_pc));
    chk("instr", 32'(oInstruction), 32'(m_instr));
    chk("valid", 32'(oInstrValid),  32'(m_valid));
    chk("err",   32'(oStackError),  32'(m_err));
`ifdef IFU_PERF_CNT_EN
    chk("count", oFetchCount, m_cnt);
`endif
  endtask

  task automatic model_reset();
    m_pc    = 16'd0;
    m_stack.delete();
    m_instr = 28'd0;
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 32'd0;
  endtask

  // One clock of the fetch stage, from the rules: halt > redirect > stall > issue
  task automatic model_next(input bit st, input bit br, input logic [15:0] tg);
    logic [27:0] w;
    logic [15:0] t;
    logic [15:0] ret_addr;
    if (m_err) return;
    if (br) begin
      m_pc    = tg;
      m_instr = 28'd0;
      m_valid = 1'b0;
      return;
    end
    if (st) return;
    w        = rom[m_pc];
    t        = {8'd0, w[23:16]};
    ret_addr = m_pc + 16'd1;
    m_instr  = w;
    m_valid  = 1'b1;
    if (w[27:24] == OP_JMP) begin
      m_pc = t;
    end else if (w[27:24] == OP_CALL) begin
      if (m_stack.size() == DEPTH) begin
        m_err = 1'b1; m_valid = 1'b0;
      end else begin
        m_stack.push_back(ret_addr);
        m_pc = t;
      end
    end else if (w[27:24] == OP_RET) begin
      if (m_stack.size() == 0) begin
        m_err = 1'b1; m_valid = 1'b0;
      end else begin
        m_pc = m_stack.pop_back();
      end
    end else begin
      m_pc = ret_addr;
    end
    if (m_valid) m_cnt = m_cnt + 32'd1;
  endtask

  // Called at a falling edge: check, drive, advance model, wait one cycle
  task automatic step(input bit st, input bit br, input logic [15:0] tg);
    compare_all();
    iStall        = st;
    iBranchTaken  = br;
    iBranchTarget = tg;
    model_next(st, br, tg);
    @(posedge Clock);
    @(negedge Clock);
  endtask

  // Called at a falling edge; reset acts immediately (asynchronous)
  task automatic do_reset();
    Reset         = 1'b1;
    iStall        = 1'b0;
    iBranchTaken  = 1'b0;
    iBranchTarget = '0;
    #1;
    chk("rst_addr",  32'(oAddress),     32'h0);
    chk("rst_instr", 32'(oInstruction), 32'h0);
    chk("rst_valid", 32'(oInstrValid),  32'h0);
    chk("rst_err",   32'(oStackError),  32'h0);
    model_reset();
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  function automatic logic [3:0] plain_op();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    while (op == OP_JMP || op == OP_CALL || op == OP_RET) op = 4'($urandom_range(0, 15));
    return op;
  endfunction

  function automatic logic [27:0] mk(input logic [3:0] op, input int tgt);
    logic [7:0] t8;
    t8 = 8'(tgt);
    return {op, t8, 16'($urandom)};
  endfunction

  task automatic fill_plain();
    for (int i = 0; i < 65536; i++) rom[i] = {plain_op(), 24'($urandom)};
  endtask

  task automatic fill_random();
    int r;
    for (int i = 0; i < 65536; i++) begin
      r = $urandom_range(0, 99);
      if (r < 5)       rom[i] = mk(OP_JMP,  $urandom_range(0, 255));
      else if (r < 13) rom[i] = mk(OP_CALL, $urandom_range(0, 255));
      else if (r < 20) rom[i] = mk(OP_RET,  0);
      else             rom[i] = {plain_op(), 24'($urandom)};
    end
  endtask

  int exp_seq [5] = '{17, 18, 19, 20, 6};

  initial begin
    @(negedge Clock);

    // Free run over plain words
    fill_plain();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 16'd0);
      chk("run_addr",  32'(oAddress), 32'(i + 1));
      chk("run_instr", 32'(oInstruction), 32'(rom[i]));
      chk("run_valid", 32'(oInstrValid), 32'd1);
    end
    $display("scenario free_run: %0d checks so far", checks);

    // CALL 17 at 5, RET at 20, then RET at 6 underflows the empty stack
    fill_plain();
    rom[5]  = mk(OP_CALL, 17);
    rom[20] = mk(OP_RET, 0);
    rom[6]  = mk(OP_RET, 0);
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 16'd0);
    chk("call_at", 32'(oAddress), 32'd5);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 16'd0);
      chk("call_seq", 32'(oAddress), 32'(exp_seq[i]));
    end
    step(0, 0, 16'd0);
    chk("empty_err",  32'(oStackError), 32'd1);
    chk("empty_addr", 32'(oAddress),    32'd6);
    $display("scenario call_ret: %0d checks so far", checks);

    // Nine nested CALLs: the ninth overflows
    fill_plain();
    for (int k = 0; k < 9; k++) rom[k * 10] = mk(OP_CALL, k * 10 + 10);
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 0, 16'd0);
    chk("nest_addr", 32'(oAddress), 32'd80);
    chk("nest_err0", 32'(oStackError), 32'd0);
    step(0, 0, 16'd0);
    chk("ovf_err",   32'(oStackError), 32'd1);
    chk("ovf_addr",  32'(oAddress),    32'd80);
    chk("ovf_valid", 32'(oInstrValid), 32'd0);
    step(0, 1, 16'd5);
    step(0, 0, 16'd0);
    chk("halt_addr",  32'(oAddress),    32'd80);
    chk("halt_valid", 32'(oInstrValid), 32'd0);
    $display("scenario overflow: %0d checks so far", checks);

    // Redirect squashes a CALL at 8; RET at 17 then underflows
    fill_plain();
    rom[8]  = mk(OP_CALL, 30);
    rom[17] = mk(OP_RET, 0);
    do_reset();
    for (int i = 0; i < 8; i++) step(0, 0, 16'd0);
    chk("sq_at", 32'(oAddress), 32'd8);
    step(0, 1, 16'd17);
    chk("sq_addr",  32'(oAddress),     32'd17);
    chk("sq_valid", 32'(oInstrValid),  32'd0);
    chk("sq_instr", 32'(oInstruction), 32'h0);
    step(0, 0, 16'd0);
    chk("sq_unf", 32'(oStackError), 32'd1);
    $display("scenario squash: %0d checks so far", checks);

    // Stall at 12, then stall with a redirect in its second cycle
    fill_plain();
    do_reset();
    for (int i = 0; i < 12; i++) step(0, 0, 16'd0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 16'd0);
      chk("stall_addr",  32'(oAddress),     32'd12);
      chk("stall_instr", 32'(oInstruction), 32'(rom[11]));
    end
    step(1, 0, 16'd0);
    step(1, 1, 16'd40);
    chk("stall_br", 32'(oAddress), 32'd40);
    step(1, 0, 16'd0);
    chk("stall_br_hold", 32'(oAddress), 32'd40);
    $display("scenario stall: %0d checks so far", checks);

    // Wrap: CALL at 0xFFFF pushes 0x0000
    fill_plain();
    rom[16'hFFFF] = mk(OP_CALL, 3);
    rom[3]        = mk(OP_RET, 0);
    do_reset();
    step(0, 1, 16'hFFFF);
    chk("wrap_at", 32'(oAddress), 32'hFFFF);
    step(0, 0, 16'd0);
    chk("wrap_call", 32'(oAddress), 32'd3);
    step(0, 0, 16'd0);
    chk("wrap_ret", 32'(oAddress), 32'd0);
    $display("scenario wrap: %0d checks so far", checks);

`ifdef IFU_PERF_CNT_EN
    // 10 issued, 2 stalls, 1 squash
    fill_plain();
    do_reset();
    for (int i = 0; i < 5; i++) step(0, 0, 16'd0);
    step(1, 0, 16'd0);
    step(1, 0, 16'd0);
    step(0, 1, 16'h0040);
    for (int i = 0; i < 5; i++) step(0, 0, 16'd0);
    chk("perf_count", oFetchCount, 32'd10);
    $display("scenario perf: %0d checks so far", checks);
`endif

    // Randomized traffic with occasional resets (including mid-call-chain)
    fill_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ((m_err && $urandom_range(0, 3) == 0) || $urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0,
             ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255)));
      end
    end
    compare_all();
    $display("scenario random: %0d checks so far", checks);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
